// File: rtl/param_divider.sv
// ============================================================================
//  Module      : param_divider
//  Description : Multi-cycle non-restoring integer divider, one quotient bit
//                per clock, signed (truncating) or unsigned per operation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 2)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_DIV,
   input  logic             ctrl_SIGNED,
   output logic [WIDTH-1:0] data_result,
   output logic [WIDTH-1:0] data_remainder,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             data_busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;
   logic             r_quo_neg;
   logic             r_rem_neg;
   logic             r_zero;

   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_step;
   logic [WIDTH-1:0] w_rem_fix;
   logic [WIDTH-1:0] w_quo_out;
   logic [WIDTH-1:0] w_rem_out;

   // -2^(W-1) negates to itself, which read as unsigned is the correct magnitude
   always_comb begin
      w_a_neg = ctrl_SIGNED & data_operandA[WIDTH-1];
      w_b_neg = ctrl_SIGNED & data_operandB[WIDTH-1];
      w_a_mag = w_a_neg ? (~data_operandA + 1'b1) : data_operandA;
      w_b_mag = w_b_neg ? (~data_operandB + 1'b1) : data_operandB;
   end

   always_comb begin
      w_shift   = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
      w_step    = r_rem[WIDTH] ? (w_shift + {1'b0, r_div}) : (w_shift - {1'b0, r_div});
      // corrected remainder lies in [0, |B|), so the low WIDTH bits suffice
      w_rem_fix = r_rem[WIDTH] ? (r_rem[WIDTH-1:0] + r_div) : r_rem[WIDTH-1:0];
      w_quo_out = r_quo_neg ? (~r_quo + 1'b1) : r_quo;
      w_rem_out = r_rem_neg ? (~w_rem_fix + 1'b1) : w_rem_fix;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_rem          <= '0;
         r_quo          <= '0;
         r_div          <= '0;
         r_quo_neg      <= 1'b0;
         r_rem_neg      <= 1'b0;
         r_zero         <= 1'b0;
         data_result    <= '0;
         data_remainder <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         data_busy      <= 1'b0;
      end else if (ctrl_DIV) begin
         r_state        <= S_RUN;
         r_cnt          <= '0;
         r_rem          <= '0;
         r_quo          <= w_a_mag;
         r_div          <= w_b_mag;
         r_quo_neg      <= w_a_neg ^ w_b_neg;
         r_rem_neg      <= w_a_neg;
         r_zero         <= (data_operandB == '0);
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         data_busy      <= 1'b1;
      end else begin
         data_resultRDY <= 1'b0;
         case (r_state)
            S_RUN: begin
               r_rem <= w_step;
               r_quo <= {r_quo[WIDTH-2:0], ~w_step[WIDTH]};
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == c_last_iter) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               data_result    <= r_zero ? '0 : w_quo_out;
               data_remainder <= r_zero ? '0 : w_rem_out;
               data_exception <= r_zero;
               data_resultRDY <= 1'b1;
               data_busy      <= 1'b0;
               r_state        <= S_DONE;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_param_divider.sv
// ============================================================================
//  Module      : tb_param_divider
//  Description : Scoreboard bench for param_divider (WIDTH = 32).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_divider;

   localparam int W   = 32;
   localparam int LAT = W + 2;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] data_operandA = '0;
   logic [W-1:0] data_operandB = '0;
   logic         ctrl_DIV = 1'b0;
   logic         ctrl_SIGNED = 1'b0;
   logic [W-1:0] data_result;
   logic [W-1:0] data_remainder;
   logic         data_exception;
   logic         data_resultRDY;
   logic         data_busy;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         e;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   param_divider #(.WIDTH(W)) dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_DIV       (ctrl_DIV),
      .ctrl_SIGNED    (ctrl_SIGNED),
      .data_result    (data_result),
      .data_remainder (data_remainder),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .data_busy      (data_busy)
   );

   always #5 clock = ~clock;

   // Reference: 64-bit arithmetic sidesteps the -2^31 / -1 overflow
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
      exp_t   ex;
      longint sa, sd, sq, sr;
      if (b == '0) begin
         ex.q = '0; ex.r = '0; ex.e = 1'b1;
         return ex;
      end
      if (sgn) begin
         sa = longint'($signed(a));
         sd = longint'($signed(b));
      end else begin
         sa = longint'({32'b0, a});
         sd = longint'({32'b0, b});
      end
      sq   = sa / sd;
      sr   = sa % sd;
      ex.q = sq[W-1:0];
      ex.r = sr[W-1:0];
      ex.e = 1'b0;
      return ex;
   endfunction

   // Called at a falling edge; returns at the falling edge of the first busy cycle
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn, input exp_t ex);
      data_operandA = a;
      data_operandB = b;
      ctrl_SIGNED   = sgn;
      ctrl_DIV      = 1'b1;
      sb.push_back(ex);
      @(negedge clock);
      ctrl_DIV = 1'b0;
   endtask

   task automatic wait_rdy(output int cyc, output bit ok);
      cyc = 1;
      ok  = 1'b0;
      while (cyc <= 200) begin
         if (data_resultRDY) begin
            ok = 1'b1;
            return;
         end
         @(negedge clock);
         cyc++;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clock);
      n_cmp++;
      if ({data_result, data_remainder} !== {2*W{1'b0}}) begin
         n_bad++;
         $display("FAIL reset_data: got q=%h r=%h, want 0/0", data_result, data_remainder);
      end
      n_cmp++;
      if ({data_exception, data_resultRDY, data_busy} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_flags: got exc/rdy/busy=%b, want 000",
                  {data_exception, data_resultRDY, data_busy});
      end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_basic();
      int   cyc;
      bit   ok;
      exp_t ex;
      start_op(32'd7, 32'd2, 1'b1, '{q: 32'd3, r: 32'd1, e: 1'b0});
      n_cmp++;
      if (data_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL busy_first: got %b, want 1", data_busy);
      end
      repeat (LAT - 2) @(negedge clock);
      n_cmp++;
      if (data_busy !== 1'b1 || data_resultRDY !== 1'b0) begin
         n_bad++;
         $display("FAIL busy_last: got busy=%b rdy=%b, want 1/0", data_busy, data_resultRDY);
      end
      @(negedge clock);
      cyc = LAT;
      wait_rdy(cyc, ok);
      cyc = ok ? cyc + LAT - 1 : -1;
      ex = sb.pop_front();
      n_cmp++;
      if (cyc != LAT || data_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_latency: got cycle %0d busy=%b, want %0d busy=0", cyc, data_busy, LAT);
      end
      n_cmp++;
      if ({data_result, data_remainder, data_exception} !== {ex.q, ex.r, ex.e}) begin
         n_bad++;
         $display("FAIL basic_value: got q=%h r=%h e=%b, want q=%h r=%h e=%b",
                  data_result, data_remainder, data_exception, ex.q, ex.r, ex.e);
      end
      @(negedge clock);
      n_cmp++;
      if (data_resultRDY !== 1'b0 || data_result !== ex.q) begin
         n_bad++;
         $display("FAIL basic_hold: got rdy=%b q=%h, want 0/%h", data_resultRDY, data_result, ex.q);
      end
   endtask

   task automatic test_signs();
      logic [W-1:0] ta [10] = '{32'd7, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'h80000000, 32'h80000000, 32'd100, 32'hFFFFFF9C, 32'd5};
      logic [W-1:0] tb [10] = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'd2, 32'd2,
                                32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFF9, 32'd10};
      logic         ts [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [W-1:0] tq [10] = '{32'd3, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h7FFFFFFF, 32'd0,
                                32'h80000000, 32'd0, 32'd14, 32'd14, 32'd0};
      logic [W-1:0] tr [10] = '{32'd1, 32'hFFFFFFFF, 32'd1, 32'd1, 32'hFFFFFFFF,
                                32'd0, 32'h80000000, 32'd2, 32'hFFFFFFFE, 32'd5};
      int   cyc;
      bit   ok;
      exp_t ex;
      for (int i = 0; i < 10; i++) begin
         start_op(ta[i], tb[i], ts[i], '{q: tq[i], r: tr[i], e: 1'b0});
         wait_rdy(cyc, ok);
         ex = sb.pop_front();
         n_cmp++;
         if (!ok || {data_result, data_remainder, data_exception} !== {ex.q, ex.r, ex.e}) begin
            n_bad++;
            $display("FAIL sign_case%0d: got q=%h r=%h e=%b rdy=%b, want q=%h r=%h e=%b",
                     i, data_result, data_remainder, data_exception, ok, ex.q, ex.r, ex.e);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_div_zero();
      int   cyc;
      bit   ok;
      exp_t ex;
      start_op(32'd123, 32'd0, 1'b1, '{q: '0, r: '0, e: 1'b1});
      wait_rdy(cyc, ok);
      ex = sb.pop_front();
      n_cmp++;
      if (!ok || cyc != LAT) begin
         n_bad++;
         $display("FAIL dz_latency: got cycle %0d (rdy=%b), want %0d", cyc, ok, LAT);
      end
      n_cmp++;
      if ({data_result, data_remainder, data_exception} !== {ex.q, ex.r, ex.e}) begin
         n_bad++;
         $display("FAIL dz_value: got q=%h r=%h e=%b, want q=%h r=%h e=%b",
                  data_result, data_remainder, data_exception, ex.q, ex.r, ex.e);
      end
      @(negedge clock);
      start_op(32'd9, 32'd3, 1'b0, '{q: 32'd3, r: 32'd0, e: 1'b0});
      n_cmp++;
      if (data_exception !== 1'b0) begin
         n_bad++;
         $display("FAIL dz_clear: got exc=%b at start, want 0", data_exception);
      end
      wait_rdy(cyc, ok);
      ex = sb.pop_front();
      n_cmp++;
      if (!ok || {data_result, data_remainder, data_exception} !== {ex.q, ex.r, ex.e}) begin
         n_bad++;
         $display("FAIL dz_next: got q=%h r=%h e=%b, want q=%h r=%h e=%b",
                  data_result, data_remainder, data_exception, ex.q, ex.r, ex.e);
      end
      @(negedge clock);
   endtask

   // Each next operation is launched in the RDY cycle of the previous one
   task automatic test_back_to_back();
      int           cyc;
      bit           ok;
      exp_t         ex;
      logic [W-1:0] a, b;
      logic         s;
      a = $urandom; b = $urandom_range(1, 20); s = 1'b1;
      start_op(a, b, s, model(a, b, s));
      for (int i = 0; i < 8; i++) begin
         wait_rdy(cyc, ok);
         ex = sb.pop_front();
         n_cmp++;
         if (!ok || cyc != LAT) begin
            n_bad++;
            $display("FAIL b2b_latency%0d: got cycle %0d (rdy=%b), want %0d", i, cyc, ok, LAT);
         end
         n_cmp++;
         if ({data_result, data_remainder, data_exception} !== {ex.q, ex.r, ex.e}) begin
            n_bad++;
            $display("FAIL b2b_value%0d: got q=%h r=%h e=%b, want q=%h r=%h e=%b",
                     i, data_result, data_remainder, data_exception, ex.q, ex.r, ex.e);
         end
         if (i < 7) begin
            a = $urandom;
            b = (i % 3 == 0) ? $urandom : 32'($urandom_range(1, 1000));
            if (i % 2 == 1) b = -b;
            s = (i % 2 == 0);
            start_op(a, b, s, model(a, b, s));
            n_cmp++;
            if (data_resultRDY !== 1'b0) begin
               n_bad++;
               $display("FAIL b2b_pulse%0d: got rdy=%b after one cycle, want 0", i, data_resultRDY);
            end
         end
      end
      @(negedge clock);
   endtask

   task automatic test_restart_reset();
      int   cyc;
      bit   ok;
      int   extra;
      exp_t ex;
      start_op(32'd1000, 32'd3, 1'b0, '{q: 32'd333, r: 32'd1, e: 1'b0});
      repeat (9) @(negedge clock);
      void'(sb.pop_front());
      start_op(32'd50, 32'hFFFFFFF9, 1'b1, '{q: 32'hFFFFFFF9, r: 32'd1, e: 1'b0});
      wait_rdy(cyc, ok);
      ex = sb.pop_front();
      n_cmp++;
      if (!ok || cyc != LAT) begin
         n_bad++;
         $display("FAIL restart_latency: got cycle %0d (rdy=%b), want %0d", cyc, ok, LAT);
      end
      n_cmp++;
      if ({data_result, data_remainder, data_exception} !== {ex.q, ex.r, ex.e}) begin
         n_bad++;
         $display("FAIL restart_value: got q=%h r=%h e=%b, want q=%h r=%h e=%b",
                  data_result, data_remainder, data_exception, ex.q, ex.r, ex.e);
      end
      extra = 0;
      repeat (40) begin
         @(negedge clock);
         if (data_resultRDY) extra++;
      end
      n_cmp++;
      if (extra != 0) begin
         n_bad++;
         $display("FAIL restart_extra_rdy: got %0d pulses, want 0", extra);
      end
      start_op(32'd77, 32'd5, 1'b0, '{q: 32'd15, r: 32'd2, e: 1'b0});
      repeat (10) @(negedge clock);
      reset = 1'b1;
      sb.delete();
      @(negedge clock);
      reset = 1'b0;
      n_cmp++;
      if ({data_result, data_remainder, data_exception, data_busy} !== {(2*W+2){1'b0}}) begin
         n_bad++;
         $display("FAIL midreset_state: got q=%h r=%h e=%b busy=%b, want all 0",
                  data_result, data_remainder, data_exception, data_busy);
      end
      extra = 0;
      repeat (50) begin
         @(negedge clock);
         if (data_resultRDY) extra++;
      end
      n_cmp++;
      if (extra != 0) begin
         n_bad++;
         $display("FAIL midreset_rdy: got %0d pulses, want 0", extra);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_div_zero();
      test_back_to_back();
      test_restart_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
